// File: rtl/bbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_pkg
//  Description : Shared types and constants for the multi-label bounding-box
//                engine: FSM state encoding, per-channel box record, the
//                cleared-box constant and a coordinate-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The box record is sized for the widest supported configuration. Each
    // channel zero-extends its own COORD_W/CNT_W registers into it.
    localparam int BBOX_COORD_MAX_W = 16;
    localparam int BBOX_CNT_MAX_W   = 32;

    typedef struct packed {
        logic [BBOX_COORD_MAX_W-1:0] xmin;
        logic [BBOX_COORD_MAX_W-1:0] xmax;
        logic [BBOX_COORD_MAX_W-1:0] ymin;
        logic [BBOX_COORD_MAX_W-1:0] ymax;
        logic [BBOX_CNT_MAX_W-1:0]   count;
    } bbox_t;

    // Mins start at all-ones and maxes at zero so the first hit sets both.
    localparam bbox_t BBOX_CLEAR = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, count: '0};

    // Bits needed to hold any x or y coordinate of a w x h image.
    function automatic int coord_width(input int w, input int h);
        int m;
        m = (w > h) ? w : h;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_ch_accum.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_ch_accum
//  Description : One channel's bounding-box accumulator. Tracks min/max x/y
//                and a saturating pixel count.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_clear        - restore the cleared box (wins over update)
//                i_update       - fold (i_x, i_y) into the box
//                i_x, i_y       - pixel coordinate
//                o_box          - current box, zero-extended into bbox_t
//  Revision    : 1.0  initial release
// ============================================================================
module bbox_ch_accum
    import bbox_pkg::*;
#(
    parameter int COORD_W = 11,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_update,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output bbox_t              o_box
);

    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_xmin  <= BBOX_CLEAR.xmin[COORD_W-1:0];
            r_xmax  <= BBOX_CLEAR.xmax[COORD_W-1:0];
            r_ymin  <= BBOX_CLEAR.ymin[COORD_W-1:0];
            r_ymax  <= BBOX_CLEAR.ymax[COORD_W-1:0];
            r_count <= BBOX_CLEAR.count[CNT_W-1:0];
        end else if (i_update) begin
            if (i_x < r_xmin) r_xmin <= i_x;
            if (i_x > r_xmax) r_xmax <= i_x;
            if (i_y < r_ymin) r_ymin <= i_y;
            if (i_y > r_ymax) r_ymax <= i_y;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_box = '{xmin:  BBOX_COORD_MAX_W'(r_xmin),
                     xmax:  BBOX_COORD_MAX_W'(r_xmax),
                     ymin:  BBOX_COORD_MAX_W'(r_ymin),
                     ymax:  BBOX_COORD_MAX_W'(r_ymax),
                     count: BBOX_CNT_MAX_W'(r_count)};

endmodule
`default_nettype wire

// File: rtl/bbox_multi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_multi_engine
//  Description : Raster-scans an IMG_W x IMG_H label image from a synchronous
//                pixel memory and builds a bounding box plus pixel count for
//                labels 1..NUM_CH in a single pass.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - frame request (accepted in IDLE/DONE)
//                busy, done      - status (SCAN/DRAIN, DONE)
//                rd_en, addr     - pixel read request, addr = y*IMG_W+x
//                rddata          - pixel label, RD_LAT cycles after rd_en
//                res_sel         - result channel (0 selects label 1)
//                res_*           - selected box/count, zero when not valid
//  Revision    : 1.0  initial release
// ============================================================================
module bbox_multi_engine
    import bbox_pkg::*;
#(
    parameter  int IMG_W   = 160,
    parameter  int IMG_H   = 120,
    parameter  int LABEL_W = 4,
    parameter  int NUM_CH  = 4,
    parameter  int RD_LAT  = 1,
    parameter  int ADDR_W  = 15,
    parameter  int COORD_W = 11,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  addr,
    input  logic [LABEL_W-1:0] rddata,
    input  logic [SEL_W-1:0]   res_sel,
    output logic               res_valid,
    output logic [COORD_W-1:0] res_xmin,
    output logic [COORD_W-1:0] res_xmax,
    output logic [COORD_W-1:0] res_ymin,
    output logic [COORD_W-1:0] res_ymax,
    output logic [CNT_W-1:0]   res_count
);

    localparam int XY_W = coord_width(IMG_W, IMG_H);
    localparam int NPIX = IMG_W * IMG_H;

    state_t            r_state, w_next;
    logic              w_start_acc, w_last, w_hit;
    logic [XY_W-1:0]   r_x, r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [RD_LAT-1:0] r_tag_v;
    logic [XY_W-1:0]   r_tag_x [RD_LAT];
    logic [XY_W-1:0]   r_tag_y [RD_LAT];
    bbox_t             w_box   [NUM_CH];
    bbox_t             w_sel;
    logic              w_sel_ok;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last      = (r_state == SCAN) && (r_addr == ADDR_W'(NPIX - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start)       w_next = SCAN;
            SCAN:       if (w_last)      w_next = DRAIN;
            DRAIN:      if (r_tag_v == '0) w_next = DONE;
            default:                     w_next = IDLE;
        endcase
    end

    assign busy  = (r_state == SCAN) || (r_state == DRAIN);
    assign done  = (r_state == DONE);
    assign rd_en = (r_state == SCAN);
    assign addr  = r_addr;

    // ------------------------------------------------------ scan counters
    // The counters return to zero after the last pixel so addr always
    // stays inside the frame.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc || w_last) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (r_state == SCAN) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == XY_W'(IMG_W - 1)) begin
                r_x <= '0;
                r_y <= r_y + XY_W'(1);
            end else begin
                r_x <= r_x + XY_W'(1);
            end
        end
    end

    // ------------------------------------------------------- tag pipeline
    // Stage RD_LAT-1 lines up with rddata for the same pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
        end else begin
            r_tag_v[0] <= (r_state == SCAN);
            for (int i = 1; i < RD_LAT; i++) r_tag_v[i] <= r_tag_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_tag_x[0] <= r_x;
        r_tag_y[0] <= r_y;
        for (int i = 1; i < RD_LAT; i++) begin
            r_tag_x[i] <= r_tag_x[i-1];
            r_tag_y[i] <= r_tag_y[i-1];
        end
    end

    // Background and labels above NUM_CH never reach any channel.
    assign w_hit = r_tag_v[RD_LAT-1] && (rddata != '0) && (int'(rddata) <= NUM_CH);

    // ------------------------------------------------------- accumulators
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        bbox_ch_accum #(
            .COORD_W (COORD_W),
            .CNT_W   (CNT_W)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_start_acc),
            .i_update (w_hit && (int'(rddata) == i + 1)),
            .i_x      (COORD_W'(r_tag_x[RD_LAT-1])),
            .i_y      (COORD_W'(r_tag_y[RD_LAT-1])),
            .o_box    (w_box[i])
        );
    end

    // ---------------------------------------------------------- result mux
    always_comb begin
        w_sel    = '0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(res_sel) == i) begin
                w_sel    = w_box[i];
                w_sel_ok = 1'b1;
            end
        end
    end

    assign res_valid = w_sel_ok && (w_sel.count != '0);
    assign res_xmin  = res_valid ? w_sel.xmin[COORD_W-1:0] : '0;
    assign res_xmax  = res_valid ? w_sel.xmax[COORD_W-1:0] : '0;
    assign res_ymin  = res_valid ? w_sel.ymin[COORD_W-1:0] : '0;
    assign res_ymax  = res_valid ? w_sel.ymax[COORD_W-1:0] : '0;
    assign res_count = res_valid ? w_sel.count[CNT_W-1:0]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_bbox_multi_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bbox_multi_engine
//  Description : Self-checking bench. Three engines share one 8x4 image:
//                u_a (RD_LAT=1), u_b (RD_LAT=1, CNT_W=4), u_c (RD_LAT=3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bbox_multi_engine;

    logic clk = 1'b0;
    logic rst, start;
    logic [0:0] res_sel;
    always #5 clk = ~clk;

    logic [3:0] img [32];

    logic        busy_a, done_a, rd_en_a, valid_a;
    logic        busy_b, done_b, rd_en_b, valid_b;
    logic        busy_c, done_c, rd_en_c, valid_c;
    logic [4:0]  addr_a, addr_b, addr_c;
    logic [3:0]  rd_a, rd_b, rd_c1, rd_c2, rd_c3;
    logic [10:0] xmin_a, xmax_a, ymin_a, ymax_a;
    logic [10:0] xmin_b, xmax_b, ymin_b, ymax_b;
    logic [10:0] xmin_c, xmax_c, ymin_c, ymax_c;
    logic [15:0] count_a, count_c;
    logic [3:0]  count_b;

    always @(posedge clk) begin
        rd_a  <= img[addr_a];
        rd_b  <= img[addr_b];
        rd_c1 <= img[addr_c];
        rd_c2 <= rd_c1;
        rd_c3 <= rd_c2;
    end

    bbox_multi_engine #(.IMG_W(8), .IMG_H(4), .LABEL_W(4), .NUM_CH(2), .RD_LAT(1),
                        .ADDR_W(5), .COORD_W(11), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .addr(addr_a), .rddata(rd_a), .res_sel(res_sel),
        .res_valid(valid_a), .res_xmin(xmin_a), .res_xmax(xmax_a),
        .res_ymin(ymin_a), .res_ymax(ymax_a), .res_count(count_a));

    bbox_multi_engine #(.IMG_W(8), .IMG_H(4), .LABEL_W(4), .NUM_CH(2), .RD_LAT(1),
                        .ADDR_W(5), .COORD_W(11), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .addr(addr_b), .rddata(rd_b), .res_sel(res_sel),
        .res_valid(valid_b), .res_xmin(xmin_b), .res_xmax(xmax_b),
        .res_ymin(ymin_b), .res_ymax(ymax_b), .res_count(count_b));

    bbox_multi_engine #(.IMG_W(8), .IMG_H(4), .LABEL_W(4), .NUM_CH(2), .RD_LAT(3),
                        .ADDR_W(5), .COORD_W(11), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .start(start), .busy(busy_c), .done(done_c),
        .rd_en(rd_en_c), .addr(addr_c), .rddata(rd_c3), .res_sel(res_sel),
        .res_valid(valid_c), .res_xmin(xmin_c), .res_xmax(xmax_c),
        .res_ymin(ymin_c), .res_ymax(ymax_c), .res_count(count_c));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int scen; int sel; int v;
        int xmin; int xmax; int ymin; int ymax; int cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic set_image(input int scen);
        for (int i = 0; i < 32; i++) img[i] = 4'd0;
        case (scen)
            2: begin img[10] = 4'd1; img[13] = 4'd1; img[27] = 4'd1; img[7] = 4'd2; end
            3: begin
                img[0] = 4'd1;
                img[1] = 4'd3; img[9] = 4'd3; img[20] = 4'd3; img[31] = 4'd3;
                img[5] = 4'd15;
            end
            4: for (int i = 0; i < 32; i++) img[i] = 4'd2;
            default: ;
        endcase
    endtask

    task automatic check_results(input int scen);
        int cb;
        for (int k = 0; k < 8; k++) begin
            if (vecs[k].scen == scen) begin
                res_sel = 1'(vecs[k].sel);
                #1;
                cb = (vecs[k].cnt > 15) ? 15 : vecs[k].cnt;
                chk($sformatf("s%0d ch%0d a.valid", scen, vecs[k].sel), int'(valid_a), vecs[k].v);
                chk($sformatf("s%0d ch%0d a.xmin",  scen, vecs[k].sel), int'(xmin_a),  vecs[k].xmin);
                chk($sformatf("s%0d ch%0d a.xmax",  scen, vecs[k].sel), int'(xmax_a),  vecs[k].xmax);
                chk($sformatf("s%0d ch%0d a.ymin",  scen, vecs[k].sel), int'(ymin_a),  vecs[k].ymin);
                chk($sformatf("s%0d ch%0d a.ymax",  scen, vecs[k].sel), int'(ymax_a),  vecs[k].ymax);
                chk($sformatf("s%0d ch%0d a.count", scen, vecs[k].sel), int'(count_a), vecs[k].cnt);
                chk($sformatf("s%0d ch%0d b.valid", scen, vecs[k].sel), int'(valid_b), vecs[k].v);
                chk($sformatf("s%0d ch%0d b.xmin",  scen, vecs[k].sel), int'(xmin_b),  vecs[k].xmin);
                chk($sformatf("s%0d ch%0d b.xmax",  scen, vecs[k].sel), int'(xmax_b),  vecs[k].xmax);
                chk($sformatf("s%0d ch%0d b.ymin",  scen, vecs[k].sel), int'(ymin_b),  vecs[k].ymin);
                chk($sformatf("s%0d ch%0d b.ymax",  scen, vecs[k].sel), int'(ymax_b),  vecs[k].ymax);
                chk($sformatf("s%0d ch%0d b.count", scen, vecs[k].sel), int'(count_b), cb);
                chk($sformatf("s%0d ch%0d c.valid", scen, vecs[k].sel), int'(valid_c), vecs[k].v);
                chk($sformatf("s%0d ch%0d c.xmin",  scen, vecs[k].sel), int'(xmin_c),  vecs[k].xmin);
                chk($sformatf("s%0d ch%0d c.xmax",  scen, vecs[k].sel), int'(xmax_c),  vecs[k].xmax);
                chk($sformatf("s%0d ch%0d c.ymin",  scen, vecs[k].sel), int'(ymin_c),  vecs[k].ymin);
                chk($sformatf("s%0d ch%0d c.ymax",  scen, vecs[k].sel), int'(ymax_c),  vecs[k].ymax);
                chk($sformatf("s%0d ch%0d c.count", scen, vecs[k].sel), int'(count_c), vecs[k].cnt);
            end
        end
    endtask

    // Called at #1 after a rising edge. Pulses start, checks the state right
    // after acceptance, then measures cycles from the start edge to done.
    task automatic run_frame(input int scen);
        int la, lb, lc, n;
        res_sel = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("s%0d accept done", scen),  int'(done_a),  0);
        chk($sformatf("s%0d accept busy", scen),  int'(busy_a),  1);
        chk($sformatf("s%0d accept rd_en", scen), int'(rd_en_a), 1);
        chk($sformatf("s%0d accept addr", scen),  int'(addr_a),  0);
        chk($sformatf("s%0d accept cleared", scen), int'(valid_c), 0);
        la = -1; lb = -1; lc = -1; n = 0;
        while ((la < 0 || lb < 0 || lc < 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done_a && la < 0) la = n;
            if (done_b && lb < 0) lb = n;
            if (done_c && lc < 0) lc = n;
        end
        chk($sformatf("s%0d latency a", scen), la, 34);
        chk($sformatf("s%0d latency b", scen), lb, 34);
        chk($sformatf("s%0d latency c", scen), lc, 36);
        chk($sformatf("s%0d busy at done", scen), int'(busy_a), 0);
    endtask

    task automatic check_idle(input string tag);
        for (int s = 0; s < 2; s++) begin
            res_sel = 1'(s);
            #1;
            chk($sformatf("%s ch%0d valid", tag, s), int'(valid_a | valid_b | valid_c), 0);
            chk($sformatf("%s ch%0d xmin",  tag, s), int'(xmin_a), 0);
            chk($sformatf("%s ch%0d count", tag, s), int'(count_a) + int'(count_c), 0);
        end
        chk({tag, " busy"},  int'(busy_a | busy_b | busy_c), 0);
        chk({tag, " done"},  int'(done_a | done_b | done_c), 0);
        chk({tag, " rd_en"}, int'(rd_en_a | rd_en_c), 0);
        chk({tag, " addr"},  int'(addr_a) + int'(addr_c), 0);
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{2, 0, 1, 2, 5, 1, 3, 3};
        vecs[3] = '{2, 1, 1, 7, 7, 0, 0, 1};
        vecs[4] = '{3, 0, 1, 0, 0, 0, 0, 1};
        vecs[5] = '{3, 1, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{4, 0, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{4, 1, 1, 0, 7, 0, 3, 32};

        rst = 1'b1; start = 1'b0; res_sel = 1'b0;
        set_image(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // rst and start in the same cycle: rst wins
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", int'(busy_a), 0);

        // Table-driven frames; frames 2..4 start from DONE
        for (int s = 1; s <= 4; s++) begin
            set_image(s);
            run_frame(s);
            check_results(s);
        end
        // Back-to-back restart from DONE recomputes with the new image
        set_image(2);
        run_frame(2);
        check_results(2);

        // start mid-SCAN is ignored, then rst aborts the frame
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("midscan busy", int'(busy_a), 1);
        chk("midscan addr", int'(addr_a), 5);
        repeat (5) @(posedge clk);
        #1;
        chk("pre-rst addr", int'(addr_a), 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("abort");
        run_frame(2);
        check_results(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bbox_multi_engine.md
Name: bbox_multi_engine

Overview:
Parametrised successor to the single-object bounding-box engine. Scans an IMG_W x IMG_H label image from a synchronous-read pixel memory in raster order. For each of NUM_CH labels it computes xmin/xmax/ymin/ymax and a pixel count in one pass. Sits between the frame RAM and the top-level controller, using a start/busy/done handshake and a channel-select result port.

Parameters:
IMG_W, 160, image width in pixels
IMG_H, 120, image height in pixels
LABEL_W, 4, bits per pixel label; label 0 is background
NUM_CH, 4, tracked labels 1..NUM_CH; labels above NUM_CH are ignored
RD_LAT, 1, memory read latency in cycles (1..4)
ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
COORD_W, 11, coordinate output width
CNT_W, 16, per-channel pixel count width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE or DONE
busy  out  1  high in SCAN and DRAIN
done  out  1  level; high in DONE, cleared when start is accepted
rd_en  out  1  pixel read strobe
addr  out  ADDR_W  pixel address, y*IMG_W+x
rddata  in  LABEL_W  pixel label, valid RD_LAT cycles after rd_en
res_sel  in  $clog2(NUM_CH)  result channel select (0 selects label 1)
res_valid  out  1  selected channel has count > 0
res_xmin, res_xmax, res_ymin, res_ymax  out  COORD_W each  selected box; all 0 when res_valid=0
res_count  out  CNT_W  selected channel pixel count, saturating

Behaviour:
- Reset: state=IDLE, busy=0, done=0, rd_en=0, addr=0. All channel accumulators are cleared: count=0, xmin/ymin=all-ones, xmax/ymax=0.
- Result outputs are combinational from the accumulators via res_sel. When res_sel >= NUM_CH, all result outputs are 0.
- States:
  - IDLE/DONE: when start is accepted, clear all accumulators, clear done, zero the x/y scan counters, go to SCAN.
  - SCAN: rd_en=1 every cycle. addr and the (x,y) counters advance by one pixel per cycle; x wraps at IMG_W-1 and y increments on the wrap. After the cycle issuing pixel IMG_W*IMG_H-1, go to DRAIN.
  - DRAIN: rd_en=0. Wait until the RD_LAT-deep tag pipeline is empty, then go to DONE.
- Tag pipeline: {valid, x, y} is delayed RD_LAT stages, aligned with rddata.
- Accumulate: when a tag is valid and 1 <= rddata <= NUM_CH, update channel rddata-1:
  - xmin = min(xmin, x), xmax = max(xmax, x), ymin = min(ymin, y), ymax = max(ymax, y)
  - count increments, saturating at 2^CNT_W-1
- Latency: start sampled at edge k. The first rd_en is high in cycle k+1 and the last in cycle k+N, where N=IMG_W*IMG_H. The final accumulator update happens at edge k+N+RD_LAT. done rises in the following cycle. The total is N+RD_LAT+1 cycles after start.
- start during SCAN or DRAIN is ignored, with no restart and no effect on results.
- start in DONE begins a new frame; the previous results are cleared in the same edge.
- start and rst together: rst wins.
- rst during SCAN or DRAIN: immediate return to IDLE; in-flight tags are discarded and results cleared.
- A channel with no pixels keeps its cleared values, and res_valid=0 masks them to 0.
- A single-pixel object gives xmin=xmax and ymin=ymax, count=1.
- Background (0) and out-of-range labels never modify any accumulator.

Decomposition:
- Shared package bbox_pkg:
  - state enum {IDLE, SCAN, DRAIN, DONE}
  - struct bbox_t {xmin, xmax, ymin, ymax, count}
  - BBOX_CLEAR constant
  - helper function for COORD_W sizing
- Sub-module bbox_ch_accum holds one channel's registers with clear/update/x/y inputs. It is instantiated NUM_CH times via generate. The top keeps the FSM, address counters, tag pipeline and result mux.

Test Plan (IMG_W=8, IMG_H=4, NUM_CH=2, RD_LAT=1 unless noted):
- All-zero image, start -> done rises 34 cycles after start; res_valid=0 and all outputs 0 for both channels.
- Label 1 at (2,1), (5,1), (3,3); label 2 at (7,0) only -> ch0 box {2,5,1,3}, count 3; ch1 box {7,7,0,0}, count 1.
- Label 3 pixels scattered (out of range) plus label 1 at (0,0) -> only ch0 updated: {0,0,0,0}, count 1; ch1 res_valid=0.
- Full image label 2 with CNT_W=4 -> ch1 box {0,7,0,3}, count saturates at 15.
- start pulsed mid-SCAN, then rst asserted 10 cycles later -> start ignored; after rst: IDLE, done=0, all results 0; a fresh start then completes normally.
- RD_LAT=3, same image as scenario 2 -> identical results; done 36 cycles after start. Back-to-back start in DONE clears and recomputes.
